cpu_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences the ROM/decoder/register/ALU/RAM datapath one instruction at a time.

---
 rtl/cpu_sequencer_if.sv | 37 +++
 rtl/cpu_sequencer.sv | 92 +++++++++
 tb/tb_cpu_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Bundles the decoder-side inputs and datapath strobes of the instruction sequencer.
// The master modport is the sequencer; the slave modport is the decoder/datapath side.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step_mode;
    logic [4:0]       opcode;
    logic             load;
    logic             ramread;
    logic             zflag;
    logic             ram_ack;
    logic             ir_load;
    logic             alu_en;
    logic             ram_req;
    logic             ram_we;
    logic             reg_we;
    logic             pc_inc;
    logic             pc_load;
    logic             busy;
    logic             halted;
    logic             mem_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, step_mode, opcode, load, ramread, zflag, ram_ack,
        output ir_load, alu_en, ram_req, ram_we, reg_we, pc_inc, pc_load,
               busy, halted, mem_err, state, instr_count
    );

    modport slave (
        output start, step_mode, opcode, load, ramread, zflag, ram_ack,
        input  ir_load, alu_en, ram_req, ram_we, reg_we, pc_inc, pc_load,
               busy, halted, mem_err, state, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM stepping the ROM/decoder/register/ALU/RAM datapath one instruction
// at a time, with run/step/halt modes and a RAM req/ack handshake guarded by a timeout.
module cpu_sequencer #(
    parameter logic [4:0] OP_HALT     = 5'd31,
    parameter logic [4:0] OP_JMP      = 5'd30,
    parameter logic [4:0] OP_BRZ      = 5'd29,
    parameter int         MEM_TIMEOUT = 8,
    parameter int         CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_sequencer_if.master       bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [7:0]       r_waitCnt;
    logic [CNT_W-1:0] r_instrCount;
    logic             r_memErr;

    logic [2:0]       w_nextState;
    logic [2:0]       w_afterRetire;
    logic             w_isBranch;
    logic             w_branchTaken;
    logic             w_timeout;
    logic             w_retire;

    // Branches retire straight out of DECODE; everything else retires in WB.
    always_comb begin
        w_isBranch    = (bus.opcode == OP_JMP) || (bus.opcode == OP_BRZ);
        w_branchTaken = (bus.opcode == OP_JMP) || ((bus.opcode == OP_BRZ) && bus.zflag);
        w_timeout     = (r_state == S_MEM) && !bus.ram_ack && (r_waitCnt == TIMEOUT_LAST);
        w_retire      = ((r_state == S_DECODE) && w_isBranch) || (r_state == S_WB);
        w_afterRetire = bus.step_mode ? S_IDLE : S_FETCH;
        w_nextState   = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_nextState = S_FETCH;
            S_FETCH:  w_nextState = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_HALT)  w_nextState = S_HALT;
                else if (w_isBranch)        w_nextState = w_afterRetire;
                else                        w_nextState = S_EXEC;
            end
            S_EXEC:   w_nextState = (bus.load || bus.ramread) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.ram_ack)            w_nextState = S_WB;
                else if (w_timeout)         w_nextState = S_HALT;
                else                        w_nextState = S_MEM;
            end
            S_WB:     w_nextState = w_afterRetire;
            S_HALT:   w_nextState = S_HALT;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // The wait counter only runs while the sequencer stays in MEM, so each access starts from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_waitCnt    <= 8'd0;
            r_instrCount <= '0;
            r_memErr     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= ((r_state == S_MEM) && (w_nextState == S_MEM)) ? r_waitCnt + 8'd1 : 8'd0;
            if (w_timeout) r_memErr <= 1'b1;
            if (w_retire)  r_instrCount <= r_instrCount + CNT_W'(1);
        end
    end

    assign bus.ir_load     = (r_state == S_FETCH);
    assign bus.alu_en      = (r_state == S_EXEC);
    assign bus.ram_req     = (r_state == S_MEM);
    assign bus.ram_we      = (r_state == S_MEM) && bus.load;
    assign bus.reg_we      = (r_state == S_WB) && !bus.load;
    assign bus.pc_inc      = (r_state == S_WB) ||
                             ((r_state == S_DECODE) && (bus.opcode == OP_BRZ) && !bus.zflag);
    assign bus.pc_load     = (r_state == S_DECODE) && w_branchTaken;
    assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.halted      = (r_state == S_HALT);
    assign bus.mem_err     = r_memErr;
    assign bus.state       = r_state;
    assign bus.instr_count = r_instrCount;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle strobe snapshots against hand-computed vectors.
// A second instance with a 4-bit counter exercises retire-count wrap in a few dozen clocks.
module tb_cpu_sequencer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    cpu_sequencer_if #(.CNT_W(16)) bus ();
    cpu_sequencer_if #(.CNT_W(4))  bus2 ();

    cpu_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    cpu_sequencer #(.CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Snapshot layout: {state, ir_load, alu_en, ram_req, ram_we, reg_we, pc_inc, pc_load, busy, halted, mem_err}
    localparam logic [12:0] SNAP_IDLE     = 13'h0;
    localparam logic [12:0] SNAP_FETCH    = {3'd1, 10'b1000000100};
    localparam logic [12:0] SNAP_DECODE   = {3'd2, 10'b0000000100};
    localparam logic [12:0] SNAP_DEC_LOAD = {3'd2, 10'b0000001100};
    localparam logic [12:0] SNAP_DEC_INC  = {3'd2, 10'b0000010100};
    localparam logic [12:0] SNAP_EXEC     = {3'd3, 10'b0100000100};
    localparam logic [12:0] SNAP_MEM_WR   = {3'd4, 10'b0011000100};
    localparam logic [12:0] SNAP_MEM_RD   = {3'd4, 10'b0010000100};
    localparam logic [12:0] SNAP_WB_REG   = {3'd5, 10'b0000110100};
    localparam logic [12:0] SNAP_WB_STORE = {3'd5, 10'b0000010100};
    localparam logic [12:0] SNAP_HALT_ERR = {3'd6, 10'b0000000011};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] snap();
        return {bus.state, bus.ir_load, bus.alu_en, bus.ram_req, bus.ram_we, bus.reg_we,
                bus.pc_inc, bus.pc_load, bus.busy, bus.halted, bus.mem_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic ld, input logic rd, input logic z);
        bus.opcode  = op;
        bus.load    = ld;
        bus.ramread = rd;
        bus.zflag   = z;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        set_instr(5'd1, 1'b0, 1'b0, 1'b0);
        do_reset();
        tests_run++;
        if (snap() !== SNAP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL reset_snap: got %h expected %h", snap(), SNAP_IDLE);
        end
        tests_run++;
        if (bus.instr_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", bus.instr_count);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_alu_op();
        logic [12:0] expSeq [4];
        expSeq = '{SNAP_FETCH, SNAP_DECODE, SNAP_EXEC, SNAP_WB_REG};
        do_reset();
        set_instr(5'd1, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if (snap() !== expSeq[c]) begin
                tests_failed++;
                $display("[TB] FAIL alu_cycle%0d: got %h expected %h", c + 1, snap(), expSeq[c]);
            end
        end
        bus.start = 1'b0;
        tick();
        tests_run++;
        if (snap() !== SNAP_FETCH || bus.instr_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL alu_retire: got snap %h count %0d expected %h count 1",
                     snap(), bus.instr_count, SNAP_FETCH);
        end
    endtask

    task automatic test_branch();
        logic [4:0]  ops   [3];
        logic        zs    [3];
        logic [12:0] decEx [3];
        ops   = '{5'd29, 5'd29, 5'd30};
        zs    = '{1'b1, 1'b0, 1'b0};
        decEx = '{SNAP_DEC_LOAD, SNAP_DEC_INC, SNAP_DEC_LOAD};
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_instr(ops[k], 1'b0, 1'b0, zs[k]);
            tick();
            tests_run++;
            if (snap() !== decEx[k]) begin
                tests_failed++;
                $display("[TB] FAIL branch%0d_decode: got %h expected %h", k, snap(), decEx[k]);
            end
            tick();
            tests_run++;
            if (snap() !== SNAP_FETCH || bus.instr_count !== 16'(k + 1)) begin
                tests_failed++;
                $display("[TB] FAIL branch%0d_retire: got snap %h count %0d expected %h count %0d",
                         k, snap(), bus.instr_count, SNAP_FETCH, k + 1);
            end
        end
    endtask

    task automatic test_ram();
        do_reset();
        set_instr(5'd1, 1'b1, 1'b0, 1'b0);
        bus.ram_ack = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 3) bus.ram_ack = 1'b1;
            tests_run++;
            if (snap() !== SNAP_MEM_WR) begin
                tests_failed++;
                $display("[TB] FAIL store_mem%0d: got %h expected %h", c, snap(), SNAP_MEM_WR);
            end
        end
        tick();
        bus.ram_ack = 1'b0;
        tests_run++;
        if (snap() !== SNAP_WB_STORE) begin
            tests_failed++;
            $display("[TB] FAIL store_wb: got %h expected %h", snap(), SNAP_WB_STORE);
        end
        tick();
        tests_run++;
        if (snap() !== SNAP_FETCH || bus.instr_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL store_retire: got snap %h count %0d expected %h count 1",
                     snap(), bus.instr_count, SNAP_FETCH);
        end
        set_instr(5'd2, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        bus.ram_ack = 1'b1;
        tick();
        tests_run++;
        if (snap() !== SNAP_MEM_RD) begin
            tests_failed++;
            $display("[TB] FAIL read_mem: got %h expected %h", snap(), SNAP_MEM_RD);
        end
        tick();
        bus.ram_ack = 1'b0;
        tests_run++;
        if (snap() !== SNAP_WB_REG) begin
            tests_failed++;
            $display("[TB] FAIL read_wb: got %h expected %h", snap(), SNAP_WB_REG);
        end
        tick();
        tests_run++;
        if (bus.instr_count !== 16'd2 || bus.ram_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_retire: got count %0d ram_req %b expected count 2 ram_req 0",
                     bus.instr_count, bus.ram_req);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_instr(5'd1, 1'b0, 1'b1, 1'b0);
        bus.ram_ack = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            tests_run++;
            if (snap() !== SNAP_MEM_RD) begin
                tests_failed++;
                $display("[TB] FAIL timeout_mem%0d: got %h expected %h", c, snap(), SNAP_MEM_RD);
            end
        end
        tick();
        tests_run++;
        if (snap() !== SNAP_HALT_ERR) begin
            tests_failed++;
            $display("[TB] FAIL timeout_halt: got %h expected %h", snap(), SNAP_HALT_ERR);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tests_run++;
        if (snap() !== SNAP_HALT_ERR || bus.instr_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL halt_ignores_start: got snap %h count %0d expected %h count 0",
                     snap(), bus.instr_count, SNAP_HALT_ERR);
        end
        do_reset();
        tests_run++;
        if (snap() !== SNAP_IDLE) begin
            tests_failed++;
            $display("[TB] FAIL halt_reset: got %h expected %h", snap(), SNAP_IDLE);
        end
    endtask

    task automatic test_step();
        do_reset();
        set_instr(5'd1, 1'b0, 1'b0, 1'b0);
        bus.step_mode = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        tests_run++;
        if (snap() !== SNAP_IDLE || bus.instr_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL step_one: got snap %h count %0d expected %h count 1",
                     snap(), bus.instr_count, SNAP_IDLE);
        end
        bus.step_mode = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        set_instr(5'd1, 1'b0, 1'b0, 1'b0);
        bus.ram_ack = 1'b0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        bus.ramread = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        tests_run++;
        if (snap() !== SNAP_MEM_RD || bus.instr_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL midmem_pre: got snap %h count %0d expected %h count 1",
                     snap(), bus.instr_count, SNAP_MEM_RD);
        end
        do_reset();
        tests_run++;
        if (snap() !== SNAP_IDLE || bus.instr_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL midmem_reset: got snap %h count %0d expected %h count 0",
                     snap(), bus.instr_count, SNAP_IDLE);
        end
        bus.ramread = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        bus2.opcode = 5'd30;
        bus2.start  = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) begin
            tick();
            tick();
        end
        tests_run++;
        if (bus2.instr_count !== 4'd15) begin
            tests_failed++;
            $display("[TB] FAIL wrap_pre: got %0d expected 15", bus2.instr_count);
        end
        tick();
        tick();
        tests_run++;
        if (bus2.instr_count !== 4'd0 || bus2.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_zero: got count %0d busy %b expected count 0 busy 1",
                     bus2.instr_count, bus2.busy);
        end
        bus2.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.step_mode  = 1'b0;
        bus.opcode     = 5'd0;
        bus.load       = 1'b0;
        bus.ramread    = 1'b0;
        bus.zflag      = 1'b0;
        bus.ram_ack    = 1'b0;
        bus2.start     = 1'b0;
        bus2.step_mode = 1'b0;
        bus2.opcode    = 5'd0;
        bus2.load      = 1'b0;
        bus2.ramread   = 1'b0;
        bus2.zflag     = 1'b0;
        bus2.ram_ack   = 1'b0;
        tick();
        test_reset();
        test_alu_op();
        test_branch();
        test_ram();
        test_timeout();
        test_step();
        test_reset_mid_mem();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
